md_ctrl: RTL and testbench

MD_CTRL -- requirements
Module: md_ctrl

---
 rtl/md_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_md_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_ctrl.sv
// md_ctrl -- multiply/divide control for the EX stage.
//
// This block handles MULT/MULTU and MTHI/MTLO in a single cycle. It sequences
// DIV/DIVU through an external multi-cycle divider, and it owns the
// architectural HI/LO registers.
//
// Ports
//   clk, rst                      clock; synchronous active-high reset
//   md_op_i[2:0]                  EX op (1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO)
//   rs_data_i, rt_data_i[31:0]    operands
//   flush_i                       cancel the EX instruction
//   stall_i                       downstream stall, EX does not advance
//   div_start_o, div_annul_o,
//   div_signed_o                  divider control
//   div_opdata1_o, div_opdata2_o  dividend / divisor
//   div_result_i[63:0]            {remainder, quotient}
//   div_ready_i                   divider result valid
//   stall_o                       request to freeze IF..EX
//   hi_o, lo_o                    architectural HI/LO
//
// Configuration
//   HILO_BYPASS_EN  defined: hi_o/lo_o show the value being written in the
//                   same cycle. Undefined (the default): hi_o/lo_o are the
//                   registered values only.
//
// state | meaning
// IDLE  | no division outstanding; single-cycle ops execute, DIV/DIVU issue
// BUSY  | divider running on latched operands, pipeline frozen
// DONE  | result written while stall_i held; wait for stall_i to drop
// ABORT | two-cycle drain after a flushed division (abort_cnt counts it)

module md_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  md_op_i,
    input  logic [31:0] rs_data_i,
    input  logic [31:0] rt_data_i,
    input  logic        flush_i,
    input  logic        stall_i,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        div_signed_o,
    output logic [31:0] div_opdata1_o,
    output logic [31:0] div_opdata2_o,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i,
    output logic        stall_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE,
        S_ABORT
    } state_t;

    state_t      state;
    logic        abort_cnt;
    logic [31:0] op1_q;
    logic [31:0] op2_q;
    logic        sign_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        is_div;
    logic        md_valid;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_wd;
    logic [31:0] lo_wd;
    logic [63:0] prod_s;
    logic [63:0] prod_u;

    assign is_div   = (md_op_i == OP_DIV) || (md_op_i == OP_DIVU);
    assign md_valid = (md_op_i != 3'b000) && (md_op_i != 3'b111);

    // The low 64 bits of a 64x64 product of sign-extended operands are the
    // signed 32x32 product, so no signed arithmetic types are needed.
    assign prod_s = {{32{rs_data_i[31]}}, rs_data_i} * {{32{rt_data_i[31]}}, rt_data_i};
    assign prod_u = {32'b0, rs_data_i} * {32'b0, rt_data_i};

    always_comb begin
        div_start_o   = 1'b0;
        div_annul_o   = 1'b0;
        div_signed_o  = sign_q;
        div_opdata1_o = op1_q;
        div_opdata2_o = op2_q;
        stall_o       = 1'b0;
        hi_we         = 1'b0;
        lo_we         = 1'b0;
        hi_wd         = hi_q;
        lo_wd         = lo_q;

        // Single-cycle HI/LO writes from IDLE and DONE.
        if ((state == S_IDLE || state == S_DONE) && !flush_i && !stall_i) begin
            case (md_op_i)
                OP_MULT:  begin hi_we = 1'b1; lo_we = 1'b1; hi_wd = prod_s[63:32]; lo_wd = prod_s[31:0]; end
                OP_MULTU: begin hi_we = 1'b1; lo_we = 1'b1; hi_wd = prod_u[63:32]; lo_wd = prod_u[31:0]; end
                OP_MTHI:  begin hi_we = 1'b1; hi_wd = rs_data_i; end
                OP_MTLO:  begin lo_we = 1'b1; lo_wd = rs_data_i; end
                default:  ;
            endcase
        end

        case (state)
            S_IDLE: begin
                if (is_div && !flush_i) begin
                    div_start_o   = 1'b1;
                    div_signed_o  = (md_op_i == OP_DIV);
                    div_opdata1_o = rs_data_i;
                    div_opdata2_o = rt_data_i;
                    stall_o       = 1'b1;
                end
            end
            S_BUSY: begin
                stall_o = 1'b1;
                if (flush_i) begin
                    // A flush outranks a result arriving in the same cycle.
                    div_annul_o = 1'b1;
                end else if (div_ready_i) begin
                    hi_we = 1'b1;
                    lo_we = 1'b1;
                    hi_wd = div_result_i[63:32];
                    lo_wd = div_result_i[31:0];
                    if (!stall_i) stall_o = 1'b0;
                end else begin
                    div_start_o = 1'b1;
                end
            end
            S_ABORT: begin
                // Hold any incoming md op until the divider has drained.
                stall_o = md_valid;
            end
            default: ;
        endcase

        if (rst) begin
            div_start_o = 1'b0;
            div_annul_o = 1'b0;
            stall_o     = 1'b0;
            hi_we       = 1'b0;
            lo_we       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            abort_cnt <= 1'b0;
            op1_q     <= 32'b0;
            op2_q     <= 32'b0;
            sign_q    <= 1'b0;
            hi_q      <= 32'b0;
            lo_q      <= 32'b0;
        end else begin
            if (hi_we) hi_q <= hi_wd;
            if (lo_we) lo_q <= lo_wd;
            case (state)
                S_IDLE: begin
                    if (is_div && !flush_i) begin
                        op1_q  <= rs_data_i;
                        op2_q  <= rt_data_i;
                        sign_q <= (md_op_i == OP_DIV);
                        state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (flush_i) begin
                        abort_cnt <= 1'b0;
                        state     <= S_ABORT;
                    end else if (div_ready_i) begin
                        state <= stall_i ? S_DONE : S_IDLE;
                    end
                end
                S_DONE: begin
                    if (!stall_i) state <= S_IDLE;
                end
                S_ABORT: begin
                    if (abort_cnt) begin
                        abort_cnt <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        abort_cnt <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef HILO_BYPASS_EN
    assign hi_o = hi_we ? hi_wd : hi_q;
    assign lo_o = lo_we ? lo_wd : lo_q;
`else
    assign hi_o = hi_q;
    assign lo_o = lo_q;
`endif

endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl. The bench drives the divider handshake by hand,
// and every expected value below is hand-computed.
`timescale 1ns/1ps

module tb_md_ctrl;

    logic        clk;
    logic        rst;
    logic [2:0]  md_op_i;
    logic [31:0] rs_data_i;
    logic [31:0] rt_data_i;
    logic        flush_i;
    logic        stall_i;
    logic        div_start_o;
    logic        div_annul_o;
    logic        div_signed_o;
    logic [31:0] div_opdata1_o;
    logic [31:0] div_opdata2_o;
    logic [63:0] div_result_i;
    logic        div_ready_i;
    logic        stall_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int checks = 0;
    int errors = 0;
    logic bypass;

    md_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .md_op_i      (md_op_i),
        .rs_data_i    (rs_data_i),
        .rt_data_i    (rt_data_i),
        .flush_i      (flush_i),
        .stall_i      (stall_i),
        .div_start_o  (div_start_o),
        .div_annul_o  (div_annul_o),
        .div_signed_o (div_signed_o),
        .div_opdata1_o(div_opdata1_o),
        .div_opdata2_o(div_opdata2_o),
        .div_result_i (div_result_i),
        .div_ready_i  (div_ready_i),
        .stall_o      (stall_o),
        .hi_o         (hi_o),
        .lo_o         (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
        md_op_i   = op;
        rs_data_i = rs;
        rt_data_i = rt;
    endtask

    initial begin
`ifdef HILO_BYPASS_EN
        bypass = 1'b1;
`else
        bypass = 1'b0;
`endif
        rst = 1'b1;
        set_op(3'd0, 32'h0, 32'h0);
        flush_i = 0; stall_i = 0; div_ready_i = 0; div_result_i = 64'h0;
        step(); step();

        // Reset values; a DIV presented during reset must not start.
        settle();
        check("rst_start", div_start_o, 0);
        check("rst_annul", div_annul_o, 0);
        check("rst_stall", stall_o, 0);
        check("rst_hi", hi_o, 0);
        check("rst_lo", lo_o, 0);
        set_op(3'd3, 32'd5, 32'd1);
        settle();
        check("rst_div_nostart", div_start_o, 0);
        set_op(3'd0, 0, 0);
        rst = 0;
        step();

        // MULTU FFFFFFFF*FFFFFFFF = FFFFFFFE_00000001
        set_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        settle();
        check("multu_stall", stall_o, 0);
        check("multu_hi_wcycle", hi_o, bypass ? 32'hFFFFFFFE : 32'h0);
        step();
        set_op(3'd0, 0, 0);
        settle();
        check("multu_hi", hi_o, 32'hFFFFFFFE);
        check("multu_lo", lo_o, 32'h00000001);
        check("multu_stall2", stall_o, 0);

        // MULT -3*5 = -15
        set_op(3'd1, 32'hFFFFFFFD, 32'd5);
        step();
        set_op(3'd0, 0, 0);
        settle();
        check("mult_hi", hi_o, 32'hFFFFFFFF);
        check("mult_lo", lo_o, 32'hFFFFFFF1);

        // MTLO held by stall_i, then written; HI untouched
        set_op(3'd6, 32'h0000AAAA, 32'h0);
        stall_i = 1;
        step();
        check("mtlo_stalled", lo_o, 32'hFFFFFFF1);
        stall_i = 0;
        step();
        set_op(3'd0, 0, 0);
        settle();
        check("mtlo_lo", lo_o, 32'h0000AAAA);
        check("mtlo_hi_keep", hi_o, 32'hFFFFFFFF);

        // MTHI flushed: no write
        set_op(3'd5, 32'h55555555, 32'h0);
        flush_i = 1;
        step();
        flush_i = 0;
        set_op(3'd0, 0, 0);
        settle();
        check("mthi_flush_keep", hi_o, 32'hFFFFFFFF);

        // DIV -7 / 2 -> quotient -3 (FFFFFFFD), remainder -1 (FFFFFFFF)
        set_op(3'd3, 32'hFFFFFFF9, 32'd2);
        settle();
        check("div_issue_start", div_start_o, 1);
        check("div_issue_signed", div_signed_o, 1);
        check("div_issue_op1", div_opdata1_o, 32'hFFFFFFF9);
        check("div_issue_op2", div_opdata2_o, 32'd2);
        check("div_issue_stall", stall_o, 1);
        step();
        rs_data_i = 32'hDEADBEEF;
        rt_data_i = 32'h12345678;
        for (int i = 0; i < 5; i++) begin
            settle();
            check("div_busy_stall", stall_o, 1);
            check("div_busy_start", div_start_o, 1);
            check("div_busy_op1", div_opdata1_o, 32'hFFFFFFF9);
            check("div_busy_op2", div_opdata2_o, 32'd2);
            check("div_busy_signed", div_signed_o, 1);
            step();
        end
        div_ready_i = 1;
        div_result_i = {32'hFFFFFFFF, 32'hFFFFFFFD};
        settle();
        check("div_ready_start", div_start_o, 0);
        check("div_ready_stall", stall_o, 0);
        step();
        div_ready_i = 0;
        set_op(3'd0, 0, 0);
        settle();
        check("div_hi", hi_o, 32'hFFFFFFFF);
        check("div_lo", lo_o, 32'hFFFFFFFD);

        // DIVU 100/0 -> zeros, then DIVU 9/4 back-to-back
        set_op(3'd4, 32'd100, 32'd0);
        settle();
        check("divu0_start", div_start_o, 1);
        check("divu0_signed", div_signed_o, 0);
        step(); step(); step();
        div_ready_i = 1;
        div_result_i = 64'h0;
        settle();
        check("divu0_ready_stall", stall_o, 0);
        step();
        div_ready_i = 0;
        set_op(3'd4, 32'd9, 32'd4);
        settle();
        check("divu0_hi", hi_o, 0);
        check("divu0_lo", lo_o, 0);
        check("divu94_start", div_start_o, 1);
        step(); step();
        div_ready_i = 1;
        div_result_i = {32'd1, 32'd2};
        step();
        div_ready_i = 0;
        set_op(3'd0, 0, 0);
        settle();
        check("divu94_hi", hi_o, 32'd1);
        check("divu94_lo", lo_o, 32'd2);

        // DIV 20/3 flushed at the 10th BUSY cycle, while a result also arrives
        set_op(3'd3, 32'd20, 32'd3);
        step();
        for (int i = 1; i < 10; i++) begin
            settle();
            check("abort_busy_annul", div_annul_o, 0);
            step();
        end
        flush_i = 1;
        div_ready_i = 1;
        div_result_i = {32'd2, 32'd6};
        settle();
        check("flush_annul", div_annul_o, 1);
        check("flush_start", div_start_o, 0);
        step();
        flush_i = 0;
        div_ready_i = 0;
        set_op(3'd3, 32'hFFFFFFF7, 32'd4);
        settle();
        check("abort0_annul", div_annul_o, 0);
        check("abort0_start", div_start_o, 0);
        check("abort0_stall", stall_o, 1);
        check("abort_hi_keep", hi_o, 32'd1);
        check("abort_lo_keep", lo_o, 32'd2);
        step();
        check("abort1_start", div_start_o, 0);
        check("abort1_stall", stall_o, 1);
        step();
        check("after_abort_start", div_start_o, 1);
        check("after_abort_op1", div_opdata1_o, 32'hFFFFFFF7);
        step();
        div_ready_i = 1;
        div_result_i = {32'hFFFFFFFF, 32'hFFFFFFFE};
        step();
        div_ready_i = 0;
        set_op(3'd0, 0, 0);
        settle();
        check("after_abort_hi", hi_o, 32'hFFFFFFFF);
        check("after_abort_lo", lo_o, 32'hFFFFFFFE);

        // DIVU 7/2 with stall_i across ready -> DONE, single write, no reissue
        set_op(3'd4, 32'd7, 32'd2);
        step(); step();
        div_ready_i = 1;
        div_result_i = {32'd1, 32'd3};
        stall_i = 1;
        settle();
        check("done_ready_start", div_start_o, 0);
        check("done_ready_stall", stall_o, 1);
        step();
        div_result_i = {32'hBAD0BAD0, 32'hBAD0BAD0};
        for (int i = 0; i < 3; i++) begin
            settle();
            check("done_start", div_start_o, 0);
            check("done_stall", stall_o, 0);
            check("done_hi", hi_o, 32'd1);
            check("done_lo", lo_o, 32'd3);
            step();
            div_ready_i = 0;
        end
        stall_i = 0;
        settle();
        check("done_release_start", div_start_o, 0);
        step();
        set_op(3'd4, 32'd15, 32'd4);
        settle();
        check("idle_after_done_start", div_start_o, 1);
        step();
        div_ready_i = 1;
        div_result_i = {32'd3, 32'd3};
        step();
        div_ready_i = 0;
        set_op(3'd0, 0, 0);
        settle();
        check("divu154_lo", lo_o, 32'd3);

        // MTHI visibility: same cycle only with bypass
        set_op(3'd5, 32'h12345678, 32'h0);
        settle();
        check("mthi_wcycle", hi_o, bypass ? 32'h12345678 : 32'd3);
        step();
        set_op(3'd0, 0, 0);
        settle();
        check("mthi_next", hi_o, 32'h12345678);
        check("mthi_lo_keep", lo_o, 32'd3);

        // Reset in the middle of a division
        set_op(3'd3, 32'd50, 32'd7);
        step();
        set_op(3'd0, 0, 0);
        settle();
        check("pre_rst_busy_start", div_start_o, 1);
        rst = 1;
        step();
        rst = 0;
        settle();
        check("midrst_start", div_start_o, 0);
        check("midrst_stall", stall_o, 0);
        check("midrst_hi", hi_o, 0);
        check("midrst_lo", lo_o, 0);
        step();
        check("midrst_idle_start", div_start_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
